packet_demux: RTL and testbench

PACKET_DEMUX -- requirements
Module: packet_demux

---
 rtl/packet_demux.sv | 185 ++++++++++++++++++
 tb/tb_packet_demux.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_demux.sv
// Routes a merged AXI-Stream to a forward port or a capture port by the one-hot
// destination field of the first beat, dropping unroutable packets and counting outcomes.
module packet_demux #(
  parameter int         C_AXIS_DATA_WIDTH  = 256,
  parameter int         C_AXIS_TUSER_WIDTH = 128,
  parameter int         C_DST_POS          = 24,
  parameter logic [7:0] C_CAP_MASK         = 8'hAA
) (
  input  logic                             axi_aclk,
  input  logic                             axi_areset,

  input  logic [C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                             s_axis_tvalid,
  input  logic                             s_axis_tlast,
  output logic                             s_axis_tready,

  output logic [C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata_0,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb_0,
  output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser_0,
  output logic                             m_axis_tvalid_0,
  output logic                             m_axis_tlast_0,
  input  logic                             m_axis_tready_0,

  output logic [C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata_1,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb_1,
  output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser_1,
  output logic                             m_axis_tvalid_1,
  output logic                             m_axis_tlast_1,
  input  logic                             m_axis_tready_1,

  input  logic                             cap_en,
  input  logic                             clr_cnt,
  output logic [95:0]                      ro_regs
);

  typedef enum logic [1:0] {HEAD, FWD0, FWD1, DROP} state_t;
  typedef enum logic [1:0] {ROUTE_P0, ROUTE_P1, ROUTE_DROP} route_t;

  state_t                              r_state;
  state_t                              w_nextState;
  route_t                              w_headRoute;
  route_t                              w_route;
  logic [7:0]                          w_dst;
  logic                                w_sReady;
  logic                                w_accept;
  logic                                w_pktEnd;
  logic [1:0]                          w_outReady;
  logic [1:0]                          w_portReady;
  logic [1:0]                          w_load;

  logic [1:0]                          r_valid;
  logic [1:0]                          r_last;
  logic [C_AXIS_DATA_WIDTH-1:0]        r_data [2];
  logic [C_AXIS_DATA_WIDTH/8-1:0]      r_strb [2];
  logic [C_AXIS_TUSER_WIDTH-1:0]       r_user [2];

  logic [31:0]                         r_pktCnt0;
  logic [31:0]                         r_pktCnt1;
  logic [31:0]                         r_dropCnt;

  assign w_dst       = s_axis_tuser[C_DST_POS +: 8];
  assign w_outReady  = {m_axis_tready_1, m_axis_tready_0};
  assign w_portReady = ~r_valid | w_outReady;
  assign w_accept    = s_axis_tvalid & w_sReady;
  assign w_pktEnd    = w_accept & s_axis_tlast;
  assign w_load[0]   = w_accept && (w_route == ROUTE_P0);
  assign w_load[1]   = w_accept && (w_route == ROUTE_P1);

  // Capture-bound packets are discarded rather than forwarded while capture is disabled.
  always_comb begin
    if (w_dst == 8'h00)
      w_headRoute = ROUTE_DROP;
    else if ((w_dst & C_CAP_MASK) != 8'h00)
      w_headRoute = cap_en ? ROUTE_P1 : ROUTE_DROP;
    else
      w_headRoute = ROUTE_P0;
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset)
      r_state <= HEAD;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (w_accept) begin
      if (s_axis_tlast)
        w_nextState = HEAD;
      else if (r_state == HEAD) begin
        case (w_headRoute)
          ROUTE_P0: w_nextState = FWD0;
          ROUTE_P1: w_nextState = FWD1;
          default:  w_nextState = DROP;
        endcase
      end
    end
  end

  // Mid-packet beats follow the route latched in the state, not the live tuser.
  always_comb begin
    w_route = ROUTE_DROP;
    case (r_state)
      HEAD:    w_route = w_headRoute;
      FWD0:    w_route = ROUTE_P0;
      FWD1:    w_route = ROUTE_P1;
      default: w_route = ROUTE_DROP;
    endcase
    w_sReady = 1'b1;
    case (w_route)
      ROUTE_P0: w_sReady = w_portReady[0];
      ROUTE_P1: w_sReady = w_portReady[1];
      default:  w_sReady = 1'b1;
    endcase
    if (axi_areset)
      w_sReady = 1'b0;
  end

  assign s_axis_tready = w_sReady;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_valid <= 2'b00;
      r_last  <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_load[i]) begin
          r_valid[i] <= 1'b1;
          r_last[i]  <= s_axis_tlast;
        end else if (w_outReady[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_load[i]) begin
        r_data[i] <= s_axis_tdata;
        r_strb[i] <= s_axis_tstrb;
        r_user[i] <= s_axis_tuser;
      end
    end
  end

  assign m_axis_tvalid_0 = r_valid[0];
  assign m_axis_tlast_0  = r_last[0];
  assign m_axis_tdata_0  = r_data[0];
  assign m_axis_tstrb_0  = r_strb[0];
  assign m_axis_tuser_0  = r_user[0];
  assign m_axis_tvalid_1 = r_valid[1];
  assign m_axis_tlast_1  = r_last[1];
  assign m_axis_tdata_1  = r_data[1];
  assign m_axis_tstrb_1  = r_strb[1];
  assign m_axis_tuser_1  = r_user[1];

  // Clear wins over a coincident increment; counts stick at all-ones.
  function automatic logic [31:0] nextCount(input logic [31:0] cur, input logic inc,
                                            input logic clr);
    if (clr)
      return 32'h0;
    if (inc && (cur != 32'hFFFF_FFFF))
      return cur + 32'd1;
    return cur;
  endfunction

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_pktCnt0 <= 32'h0;
      r_pktCnt1 <= 32'h0;
      r_dropCnt <= 32'h0;
    end else begin
      r_pktCnt0 <= nextCount(r_pktCnt0, w_pktEnd && (w_route == ROUTE_P0), clr_cnt);
      r_pktCnt1 <= nextCount(r_pktCnt1, w_pktEnd && (w_route == ROUTE_P1), clr_cnt);
      r_dropCnt <= nextCount(r_dropCnt, w_pktEnd && (w_route == ROUTE_DROP), clr_cnt);
    end
  end

  assign ro_regs = {r_dropCnt, r_pktCnt1, r_pktCnt0};

endmodule

// File: tb/tb_packet_demux.sv
// Self-checking bench for packet_demux: directed scenarios followed by randomized packets,
// compared against a packet-level reference model of routing, back-pressure and counters.
module tb_packet_demux;

  localparam int         W        = 256;
  localparam int         SW       = W / 8;
  localparam int         U        = 128;
  localparam int         DST_POS  = 24;
  localparam logic [7:0] CAP_MASK = 8'hAA;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] strb;
    logic [U-1:0]  user;
    logic          last;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  s_axis_tdata = '0;
  logic [SW-1:0] s_axis_tstrb = '0;
  logic [U-1:0]  s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [W-1:0]  m_axis_tdata_0, m_axis_tdata_1;
  logic [SW-1:0] m_axis_tstrb_0, m_axis_tstrb_1;
  logic [U-1:0]  m_axis_tuser_0, m_axis_tuser_1;
  logic          m_axis_tvalid_0, m_axis_tvalid_1;
  logic          m_axis_tlast_0, m_axis_tlast_1;
  logic          m_axis_tready_0 = 1'b1;
  logic          m_axis_tready_1 = 1'b1;
  logic          cap_en = 1'b1;
  logic          clr_cnt = 1'b0;
  logic [95:0]   ro_regs;

  packet_demux #(
    .C_AXIS_DATA_WIDTH (W),
    .C_AXIS_TUSER_WIDTH(U),
    .C_DST_POS         (DST_POS),
    .C_CAP_MASK        (CAP_MASK)
  ) dut (
    .axi_aclk       (clock),
    .axi_areset     (reset),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tstrb   (s_axis_tstrb),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata_0 (m_axis_tdata_0),
    .m_axis_tstrb_0 (m_axis_tstrb_0),
    .m_axis_tuser_0 (m_axis_tuser_0),
    .m_axis_tvalid_0(m_axis_tvalid_0),
    .m_axis_tlast_0 (m_axis_tlast_0),
    .m_axis_tready_0(m_axis_tready_0),
    .m_axis_tdata_1 (m_axis_tdata_1),
    .m_axis_tstrb_1 (m_axis_tstrb_1),
    .m_axis_tuser_1 (m_axis_tuser_1),
    .m_axis_tvalid_1(m_axis_tvalid_1),
    .m_axis_tlast_1 (m_axis_tlast_1),
    .m_axis_tready_1(m_axis_tready_1),
    .cap_en         (cap_en),
    .clr_cnt        (clr_cnt),
    .ro_regs        (ro_regs)
  );

  always #5 clock = ~clock;

  // Reference model state: one pending-beat slot per output, expected beat queues,
  // the route chosen at the start of the current packet, and expected counters.
  beat_t       expQ0[$];
  beat_t       expQ1[$];
  bit          slotFull0, slotFull1;
  bit          inPkt;
  int          curRoute;
  logic [31:0] expCnt0, expCnt1, expDrop;
  bit          lastAccept;
  bit          randMode;
  int          checks = 0;
  int          passes = 0;
  logic [7:0]  dstTab [8] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h80, 8'h03, 8'h50};

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    if (observed === expected)
      passes++;
    else
      $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
  endtask

  // 0 = forward port, 1 = capture port, 2 = drop
  function automatic int routeOf(input logic [7:0] dst, input logic cap);
    if (dst == 8'h00)
      return 2;
    if ((dst & CAP_MASK) != 8'h00)
      return cap ? 1 : 2;
    return 0;
  endfunction

  function automatic logic [31:0] satInc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  task automatic clearModel();
    expQ0.delete();
    expQ1.delete();
    slotFull0 = 0;
    slotFull1 = 0;
    inPkt     = 0;
    curRoute  = 2;
    expCnt0   = '0;
    expCnt1   = '0;
    expDrop   = '0;
  endtask

  // One clock: observe and update the model on the falling edge, then advance past
  // the rising edge and refresh randomized sideband inputs.
  task automatic tick();
    int    route;
    bit    acc;
    bit    expReady;
    beat_t e;
    @(negedge clock);
    acc   = 0;
    route = 2;
    if (reset) begin
      checkOutput("rstTready", 256'(s_axis_tready), 256'(1'b0));
      checkOutput("rstValid", 256'({m_axis_tvalid_1, m_axis_tvalid_0}), 256'(2'b00));
    end else begin
      checkOutput("counters", 256'(ro_regs), 256'({expDrop, expCnt1, expCnt0}));
      checkOutput("valid0", 256'(m_axis_tvalid_0), 256'(slotFull0));
      checkOutput("valid1", 256'(m_axis_tvalid_1), 256'(slotFull1));
      if (m_axis_tvalid_0 && m_axis_tready_0) begin
        if (expQ0.size() == 0)
          checkOutput("port0Pending", 256'(expQ0.size()), 256'(1));
        else begin
          e = expQ0.pop_front();
          checkOutput("port0Data", 256'(m_axis_tdata_0), 256'(e.data));
          checkOutput("port0Ctl", 256'({m_axis_tuser_0, m_axis_tstrb_0, m_axis_tlast_0}),
                      256'({e.user, e.strb, e.last}));
        end
      end
      if (m_axis_tvalid_1 && m_axis_tready_1) begin
        if (expQ1.size() == 0)
          checkOutput("port1Pending", 256'(expQ1.size()), 256'(1));
        else begin
          e = expQ1.pop_front();
          checkOutput("port1Data", 256'(m_axis_tdata_1), 256'(e.data));
          checkOutput("port1Ctl", 256'({m_axis_tuser_1, m_axis_tstrb_1, m_axis_tlast_1}),
                      256'({e.user, e.strb, e.last}));
        end
      end
      if (s_axis_tvalid) begin
        route = inPkt ? curRoute : routeOf(s_axis_tuser[DST_POS +: 8], cap_en);
        if (route == 0)
          expReady = !slotFull0 || m_axis_tready_0;
        else if (route == 1)
          expReady = !slotFull1 || m_axis_tready_1;
        else
          expReady = 1;
        checkOutput("sReady", 256'(s_axis_tready), 256'(expReady));
        acc = s_axis_tready;
      end
      e.data = s_axis_tdata;
      e.strb = s_axis_tstrb;
      e.user = s_axis_tuser;
      e.last = s_axis_tlast;
      if (acc && route == 0) begin
        expQ0.push_back(e);
        slotFull0 = 1;
      end else if (m_axis_tready_0)
        slotFull0 = 0;
      if (acc && route == 1) begin
        expQ1.push_back(e);
        slotFull1 = 1;
      end else if (m_axis_tready_1)
        slotFull1 = 0;
      if (acc && s_axis_tlast) begin
        if (route == 0)
          expCnt0 = satInc(expCnt0);
        else if (route == 1)
          expCnt1 = satInc(expCnt1);
        else
          expDrop = satInc(expDrop);
      end
      if (clr_cnt) begin
        expCnt0 = '0;
        expCnt1 = '0;
        expDrop = '0;
      end
      if (acc) begin
        if (s_axis_tlast)
          inPkt = 0;
        else if (!inPkt) begin
          inPkt    = 1;
          curRoute = route;
        end
      end
    end
    lastAccept = acc;
    @(posedge clock);
    #1;
    if (randMode) begin
      m_axis_tready_0 = ($urandom_range(0, 3) != 0);
      m_axis_tready_1 = ($urandom_range(0, 3) != 0);
      cap_en          = ($urandom_range(0, 3) != 0);
      clr_cnt         = ($urandom_range(0, 59) == 0);
    end else begin
      clr_cnt = 1'b0;
    end
  endtask

  task automatic waitAccept();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!lastAccept && n < 100);
    if (!lastAccept)
      checkOutput("acceptTimeout", 256'(lastAccept), 256'(1'b1));
  endtask

  // Asynchronous reset between clock edges; outputs must drop before the next edge.
  task automatic assertReset();
    #1 reset = 1'b1;
    #1;
    checkOutput("rstAsyncValid", 256'({m_axis_tvalid_1, m_axis_tvalid_0}), 256'(2'b00));
    checkOutput("rstAsyncLast", 256'({m_axis_tlast_1, m_axis_tlast_0}), 256'(2'b00));
    checkOutput("rstAsyncTready", 256'(s_axis_tready), 256'(1'b0));
    checkOutput("rstAsyncCnt", 256'(ro_regs), 256'(0));
    clearModel();
    s_axis_tvalid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input int len, input logic [7:0] dst, input int stallBeat,
                               input bit corrupt, input bit clrOnLast);
    logic [W-1:0] d;
    logic [U-1:0] u;
    for (int b = 0; b < len; b++) begin
      if (randMode && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        tick();
      end
      for (int k = 0; k < W / 32; k++) d[k*32 +: 32] = $urandom();
      for (int k = 0; k < U / 32; k++) u[k*32 +: 32] = $urandom();
      u[DST_POS +: 8] = dst;
      if (corrupt && b > 0) begin
        u[DST_POS +: 8] = randMode ? 8'($urandom()) : 8'h01;
        cap_en          = ~cap_en;
      end
      s_axis_tdata  = d;
      s_axis_tuser  = u;
      s_axis_tstrb  = SW'($urandom());
      s_axis_tlast  = (b == len - 1);
      s_axis_tvalid = 1'b1;
      if (b == stallBeat) begin
        m_axis_tready_1 = 1'b0;
        repeat (5) begin
          tick();
          checkOutput("stallTready", 256'(s_axis_tready), 256'(1'b0));
          checkOutput("stallNoAccept", 256'(lastAccept), 256'(1'b0));
        end
        m_axis_tready_1 = 1'b1;
      end
      if (clrOnLast && b == len - 1)
        clr_cnt = 1'b1;
      waitAccept();
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    s_axis_tvalid   = 1'b0;
    m_axis_tready_0 = 1'b1;
    m_axis_tready_1 = 1'b1;
    repeat (4) tick();
    checkOutput("drainQ0", 256'(expQ0.size()), 256'(0));
    checkOutput("drainQ1", 256'(expQ1.size()), 256'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed hang required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    randMode = 0;
    clearModel();
    assertReset();

    // Three-beat forward packet.
    applyStimulus(3, 8'h01, -1, 0, 0);
    drain();
    checkOutput("pktCnt0", 256'(ro_regs[31:0]), 256'(32'd1));

    // Capture packet, then the same destination dropped while capture is off.
    cap_en = 1'b1;
    applyStimulus(2, 8'h02, -1, 0, 0);
    drain();
    checkOutput("pktCnt1", 256'(ro_regs[63:32]), 256'(32'd1));
    cap_en = 1'b0;
    applyStimulus(3, 8'h02, -1, 0, 0);
    drain();
    checkOutput("dropCnt", 256'(ro_regs[95:64]), 256'(32'd1));

    // Capture port stalled mid-packet.
    cap_en = 1'b1;
    applyStimulus(4, 8'h02, 2, 0, 0);
    drain();

    // tuser and cap_en disturbed after the first beat.
    cap_en = 1'b1;
    applyStimulus(4, 8'h02, -1, 1, 0);
    drain();
    cap_en = 1'b1;
    checkOutput("pktCnt1Held", 256'(ro_regs[63:32]), 256'(32'd3));

    // Saturation, then clear coinciding with a tlast accept.
    force dut.r_pktCnt0 = 32'hFFFF_FFFF;
    #1;
    release dut.r_pktCnt0;
    expCnt0 = 32'hFFFF_FFFF;
    applyStimulus(2, 8'h01, -1, 0, 0);
    drain();
    checkOutput("pktCnt0Sat", 256'(ro_regs[31:0]), 256'(32'hFFFF_FFFF));
    applyStimulus(2, 8'h01, -1, 0, 1);
    drain();
    checkOutput("clrPrecedence", 256'(ro_regs), 256'(0));

    // Reset in the middle of a packet, then a single-beat packet.
    applyStimulus(1, 8'h01, -1, 0, 0);
    s_axis_tuser[DST_POS +: 8] = 8'h01;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    waitAccept();
    s_axis_tdata = {8{32'hDEAD_BEEF}};
    waitAccept();
    checkOutput("preRstValid0", 256'(m_axis_tvalid_0), 256'(slotFull0));
    assertReset();
    applyStimulus(1, 8'h01, -1, 0, 0);
    drain();
    checkOutput("postRstCnt", 256'(ro_regs), 256'({32'd0, 32'd0, 32'd1}));

    // Randomized traffic with random back-pressure, cap_en and clears.
    randMode = 1;
    repeat (150) begin
      applyStimulus($urandom_range(1, 5), dstTab[$urandom_range(0, 7)], -1,
                    ($urandom_range(0, 3) == 0), 0);
    end
    randMode = 0;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
